// File: rtl/ipg_tx_inject_if.sv
// Chunk-offer handshake between the injection source and ipg_tx_inject.
// The source drives data/len/valid; the injector answers with ready.
interface ipg_tx_inject_if;
    logic [47:0] inj_data;
    logic [5:0]  inj_len;
    logic        inj_valid;
    logic        inj_ready;

    modport master (
        output inj_data,
        output inj_len,
        output inj_valid,
        input  inj_ready
    );

    modport slave (
        input  inj_data,
        input  inj_len,
        input  inj_valid,
        output inj_ready
    );
endinterface

// File: rtl/ipg_tx_inject.sv
// Embeds queued data chunks into XGMII inter-packet gaps as MARK_CHAR-tagged control blocks.
// Optional macro IPG_TX_INJECT_STATS_EN enables the saturating injected-block counter.
module ipg_tx_inject #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  MARK_CHAR  = 8'h5C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ipg_tx_inject_if.slave       inj,
    input  logic [63:0]          xgmii_txd_in,
    input  logic [7:0]           xgmii_txc_in,
    output logic [63:0]          xgmii_txd_out,
    output logic [7:0]           xgmii_txc_out,
    output logic                 inj_len_err,
    output logic [15:0]          inj_count
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [63:0] IDLE_D   = {8{8'h07}};

    typedef enum logic [1:0] {StFrame, StGapHold, StGapOpen} state_e;

    state_e        state_q;
    logic [47:0]   mem_data [FIFO_DEPTH];
    logic [5:0]    mem_len  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic len_ok, offer, push, bad_len, in_idle, pop;

    assign inj.inj_ready = (count_q != FULL_CNT);
    assign len_ok  = (inj.inj_len != 6'd0) && (inj.inj_len <= 6'd48);
    assign offer   = inj.inj_valid && inj.inj_ready;
    assign push    = offer && len_ok;
    assign bad_len = offer && !len_ok;
    assign in_idle = (xgmii_txc_in == 8'hFF) && (xgmii_txd_in == IDLE_D);
    // Registered occupancy means a chunk written this cycle cannot be popped until the next.
    assign pop     = (count_q != '0) && (state_q == StGapOpen) && in_idle;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= inj.inj_data;
            mem_len[wr_ptr_q]  <= inj.inj_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFrame;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inj_len_err   <= 1'b0;
            xgmii_txd_out <= IDLE_D;
            xgmii_txc_out <= 8'hFF;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            inj_len_err <= bad_len;

            // Decisions above use state_q, so the first two idles after a frame always pass.
            unique case (state_q)
                StFrame:   state_q <= in_idle ? StGapHold : StFrame;
                StGapHold: state_q <= in_idle ? StGapOpen : StFrame;
                StGapOpen: state_q <= in_idle ? StGapOpen : StFrame;
                default:   state_q <= StFrame;
            endcase

            if (pop) begin
                xgmii_txd_out <= {mem_data[rd_ptr_q], 2'b00, mem_len[rd_ptr_q], MARK_CHAR};
                xgmii_txc_out <= 8'h01;
            end else begin
                xgmii_txd_out <= xgmii_txd_in;
                xgmii_txc_out <= xgmii_txc_in;
            end
        end
    end

`ifdef IPG_TX_INJECT_STATS_EN
    logic [15:0] inj_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_count_q <= '0;
        end else if (pop && (inj_count_q != 16'hFFFF)) begin
            inj_count_q <= inj_count_q + 16'd1;
        end
    end

    assign inj_count = inj_count_q;
`else
    assign inj_count = '0;
`endif

endmodule

// File: tb/tb_ipg_tx_inject.sv
// Directed self-checking bench for ipg_tx_inject (FIFO_DEPTH 8, MARK_CHAR 8'h5C).
module tb_ipg_tx_inject;
    localparam logic [63:0] IDLE_D  = {8{8'h07}};
    localparam logic [63:0] FRAME_D = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] FRAME2  = 64'h0011_2233_4455_6677;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] txd_in, txd_out;
    logic [7:0]  txc_in, txc_out;
    logic        len_err;
    logic [15:0] count;
    int          checks = 0;
    int          errors = 0;

    ipg_tx_inject_if bus ();

    ipg_tx_inject #(
        .FIFO_DEPTH (8),
        .MARK_CHAR  (8'h5C)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inj           (bus),
        .xgmii_txd_in  (txd_in),
        .xgmii_txc_in  (txc_in),
        .xgmii_txd_out (txd_out),
        .xgmii_txc_out (txc_out),
        .inj_len_err   (len_err),
        .inj_count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] chunk_d(input int i);
        return 48'hBEEF_0000_0000 | 48'(i);
    endfunction

    function automatic logic [5:0] chunk_l(input int i);
        return 6'(i + 1);
    endfunction

    function automatic logic [63:0] word(input int i);
        return {chunk_d(i), 2'b00, chunk_l(i), 8'h5C};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xin(input logic [63:0] d, input logic [7:0] c);
        txd_in = d;
        txc_in = c;
    endtask

    task automatic push1(input logic [47:0] d, input logic [5:0] l);
        bus.inj_valid = 1'b1;
        bus.inj_data  = d;
        bus.inj_len   = l;
        tick();
        bus.inj_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] d, input logic [7:0] c);
        check({tag, "_txd"}, txd_out, d);
        check({tag, "_txc"}, {56'd0, txc_out}, {56'd0, c});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.inj_valid = 1'b0;
        bus.inj_data  = '0;
        bus.inj_len   = '0;
        xin(FRAME_D, 8'h00);
        tick();
        tick();
        chk_out("reset", IDLE_D, 8'hFF);
        check("reset_ready", 64'(bus.inj_ready), 64'd1);
        check("reset_err", 64'(len_err), 64'd0);
        check("reset_count", 64'(count), 64'd0);

        // Single 48-bit chunk lands on the third idle of the gap.
        rst_n = 1'b1;
        push1(48'hA5A5_0000_1234, 6'd48);
        tick();
        chk_out("f1_frame", FRAME_D, 8'h00);
        xin(IDLE_D, 8'hFF);
        tick(); chk_out("f1_idle1", IDLE_D, 8'hFF);
        tick(); chk_out("f1_idle2", IDLE_D, 8'hFF);
        tick(); chk_out("f1_inj", 64'hA5A5_0000_1234_305C, 8'h01);
        tick(); chk_out("f1_idle4", IDLE_D, 8'hFF);
        xin(FRAME_D, 8'h00);
        tick(); chk_out("f1_frame2", FRAME_D, 8'h00);

        // Bad lengths rejected, nothing queued.
        bus.inj_valid = 1'b1;
        bus.inj_data  = 48'h1;
        bus.inj_len   = 6'd0;
        tick(); check("len0_err", 64'(len_err), 64'd1);
        bus.inj_len   = 6'd49;
        tick(); check("len49_err", 64'(len_err), 64'd1);
        bus.inj_valid = 1'b0;
        tick(); check("len_err_clear", 64'(len_err), 64'd0);
        xin(IDLE_D, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_out($sformatf("badlen_gap%0d", i), IDLE_D, 8'hFF);
        end
        xin(FRAME_D, 8'h00);
        tick();

        // Fill the FIFO, hold a ninth chunk, then drain in order across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            bus.inj_valid = 1'b1;
            bus.inj_data  = chunk_d(i);
            bus.inj_len   = chunk_l(i);
            check($sformatf("fill_ready%0d", i), 64'(bus.inj_ready), 64'd1);
            tick();
        end
        check("full_ready", 64'(bus.inj_ready), 64'd0);
        bus.inj_data = chunk_d(8);
        bus.inj_len  = chunk_l(8);
        tick(); check("full_hold", 64'(bus.inj_ready), 64'd0);
        xin(IDLE_D, 8'hFF);
        tick(); check("full_i1_ready", 64'(bus.inj_ready), 64'd0);
        chk_out("full_i1", IDLE_D, 8'hFF);
        tick(); check("full_i2_ready", 64'(bus.inj_ready), 64'd0);
        tick(); chk_out("drain0", word(0), 8'h01);
        check("ready_after_pop", 64'(bus.inj_ready), 64'd1);
        tick(); chk_out("drain1", word(1), 8'h01);
        check("ready_pushpop", 64'(bus.inj_ready), 64'd1);
        bus.inj_valid = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick(); chk_out($sformatf("drain%0d", i), word(i), 8'h01);
        end
        tick(); chk_out("drain_empty", IDLE_D, 8'hFF);
        xin(FRAME_D, 8'h00);
        tick();

        // Two-idle gap never injects.
        push1(chunk_d(20), chunk_l(20));
        tick(); chk_out("g2_frame", FRAME_D, 8'h00);
        xin(IDLE_D, 8'hFF);
        tick(); chk_out("g2_idle1", IDLE_D, 8'hFF);
        tick(); chk_out("g2_idle2", IDLE_D, 8'hFF);
        xin(FRAME2, 8'h00);
        tick(); chk_out("g2_frame2", FRAME2, 8'h00);

        // Reset in an open gap with three chunks queued.
        push1(chunk_d(21), chunk_l(21));
        push1(chunk_d(22), chunk_l(22));
        xin(IDLE_D, 8'hFF);
        tick();
        tick();
        rst_n = 1'b0;
        tick(); chk_out("rst_mid", IDLE_D, 8'hFF);
        check("rst_mid_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        xin(FRAME_D, 8'h00);
        tick(); chk_out("rst_frame", FRAME_D, 8'h00);
        xin(IDLE_D, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_out($sformatf("rst_gap%0d", i), IDLE_D, 8'hFF);
        end

        // Five injections for the statistics counter.
        xin(FRAME_D, 8'h00);
        for (int i = 10; i < 15; i++) push1(chunk_d(i), chunk_l(i));
        tick();
        xin(IDLE_D, 8'hFF);
        tick();
        tick();
        for (int i = 10; i < 15; i++) begin
            tick(); chk_out($sformatf("stat_inj%0d", i), word(i), 8'h01);
        end
`ifdef IPG_TX_INJECT_STATS_EN
        check("inj_count", 64'(count), 64'd5);
`else
        check("inj_count", 64'(count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
